// File: rtl/fre_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : fre_div_prog
// Brief    : Runtime-programmable integer clock divider with 50% duty on odd
//            ratios, glitch-free ratio changes, clean start/stop and tick.
// Revision : 1.0 - initial release
// ============================================================================
module fre_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic [WIDTH-1:0] div_cur,
    output logic             clk_d,
    output logic             tick
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(2);

    generate
        if ((DEFAULT_DIV < 2) ||
            (longint'(DEFAULT_DIV) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_default_div
            $error("fre_div_prog: DEFAULT_DIV out of range for WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_cur;
    logic             r_pend_vld;
    logic [WIDTH-1:0] r_pend;
    logic             r_p;
    logic             r_n;
    logic             r_tick;
    logic             r_ack;
    logic             r_err;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic             w_pend_vld_nxt;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic             w_p_nxt;
    logic             w_tick_nxt;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_last;
    logic             w_boundary;
    logic             w_load_ok;
    logic             w_load_bad;

    assign w_load_ok  = div_load && (div_in >= C_MIN_DIV);
    assign w_load_bad = div_load && (div_in <  C_MIN_DIV);
    assign w_last     = r_div_cur - 1'b1;
    assign w_boundary = (r_state == ST_RUN) && (r_cnt == w_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div_cur;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_nxt     = r_pend;
        w_ack_nxt      = 1'b0;
        w_err_nxt      = w_load_bad;

        if (w_load_ok) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_nxt     = div_in;
        end

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (r_pend_vld) begin
                    w_div_nxt      = r_pend;
                    w_ack_nxt      = 1'b1;
                    w_pend_vld_nxt = w_load_ok;
                end
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (!en) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_load_ok) begin
                        // A load landing on the boundary edge bypasses the slot.
                        w_div_nxt      = div_in;
                        w_ack_nxt      = 1'b1;
                        w_pend_vld_nxt = 1'b0;
                    end else if (r_pend_vld) begin
                        w_div_nxt      = r_pend;
                        w_ack_nxt      = 1'b1;
                        w_pend_vld_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Output phase is derived from the post-edge count and ratio so the
        // first high phase begins on the very edge that starts the period.
        w_half     = w_div_nxt >> 1;
        w_p_nxt    = (w_state_nxt == ST_RUN) && (w_cnt_nxt < w_half);
        w_tick_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div_cur  <= C_DEFAULT_DIV;
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
            r_p        <= 1'b0;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_div_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend     <= w_pend_nxt;
            r_p        <= w_p_nxt;
            r_tick     <= w_tick_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Half-cycle-late copy stretches the high phase by half a clk for odd N.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_n <= 1'b0;
        end else begin
            r_n <= r_p;
        end
    end

    assign clk_d   = r_div_cur[0] ? (r_p | r_n) : r_p;
    assign tick    = r_tick;
    assign div_ack = r_ack;
    assign div_err = r_err;
    assign div_cur = r_div_cur;

endmodule
`default_nettype wire
